imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
Shares the single-port synchronous instruction ROM/RAM between two requesters: the fetch stage (PC-driven, read-only) and the program loader/debug port (read/write).
Issues at most one memory access per cycle and returns tagged read data after a fixed latency.
Stalls the fetch stage when it loses arbitration.
Sits between the IFU PC register, the loader, and the memory macro.

Parameters:
BASE, 32'h00003000, byte address mapped to memory word 0
ADDR_W, 13, memory word-address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, memory read latency in cycles (1..4)
MAX_LD, 4, max consecutive loader grants while fetch is waiting

Ports:
clk  in  1  sole clock; memory is clocked on the same edge
clr  in  1  asynchronous, active-low reset
if_req  in  1  fetch request
if_addr  in  32  fetch byte address (PC)
if_gnt  out  1  fetch accepted this cycle
if_stall  out  1  if_req && !if_gnt; holds PC
if_rvalid  out  1  fetch read data valid
if_rdata  out  32  fetched instruction
if_err  out  1  with if_rvalid: address out of range or misaligned
ld_req  in  1  loader request
ld_we  in  4  byte write enables; 0 = read
ld_addr  in  32  loader byte address
ld_wdata  in  32  loader write data
ld_gnt  out  1  loader accepted this cycle
ld_rvalid  out  1  loader read data valid (reads only)
ld_rdata  out  32  loader read data
ld_err  out  1  with ld_rvalid or ld_gnt (write): bad address
mem_en  out  1  memory enable
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, RD_LAT cycles after mem_en

Behaviour:
- Handshake: a request is accepted when req and gnt are both high in the same cycle. The requester holds req/addr/data stable until accepted. gnt is combinational from req, addresses and the streak counter.
- Arbitration:
  - Loader wins by default.
  - Fetch wins when ld_req=0, or when ld_streak==MAX_LD and if_req=1.
  - At most one gnt per cycle; no gnt without req.
- ld_streak (width clog2(MAX_LD+1)):
  - +1 on each loader grant while if_req=1.
  - Cleared on a fetch grant or any cycle with if_req=0.
  - Saturates at MAX_LD.
- Address check: off = addr-BASE (32-bit wrap). Valid iff off[1:0]==0 and off < 4*DEPTH.
  - mem_addr = off[ADDR_W+1:2].
  - An invalid request is still granted, but mem_en=0 for it.
- Memory drive (combinational, same cycle as grant):
  - mem_en=1 for a valid granted request.
  - mem_we = ld_we for a loader grant; 0 for a fetch grant.
  - mem_wdata = ld_wdata.
  - With no grant: mem_en=0 and mem_we=0.
- Response pipeline: an RD_LAT-deep shift register of {valid, owner, err}.
  - A read grant (fetch, or loader with ld_we==0) pushes valid=1.
  - At the output: rvalid pulses on the owner's port for 1 cycle, exactly RD_LAT cycles after the grant.
  - rdata = mem_rdata, or 32'h0 if err.
  - Back-to-back grants give back-to-back responses, in order.
- Writes produce no rvalid. ld_err is asserted combinationally in the grant cycle for an invalid write, and the write is dropped.
- if_rdata/ld_rdata hold 0 when the matching rvalid=0.
- Reset (clr=0, asynchronous): streak=0, pipeline cleared. All outputs are 0 except combinational gnt/stall, which are also forced to 0 while clr=0. Reads in flight at reset are dropped, never delivered.
- The block never reorders or duplicates responses, and never asserts if_rvalid and ld_rvalid from the same grant.

Test Plan:
1. Reset then if_req=1, if_addr=0x3000, ld_req=0 → if_gnt=1, mem_addr=0, mem_en=1. if_rvalid=1 one cycle later with if_rdata=mem[0].
2. Fetch stream 0x3000, 0x3004, 0x3008 on consecutive cycles → three back-to-back if_rvalid carrying mem[0], mem[1], mem[2], in order, if_stall=0 throughout.
3. ld_req and if_req both held for 10 cycles, MAX_LD=4 → grant pattern L,L,L,L,F,L,L,L,L,F. if_stall=1 exactly on the loader-granted cycles.
4. Loader write ld_we=4'b0011, ld_addr=0x3010, ld_wdata=0xAABBCCDD → mem_we=0011, mem_addr=4, no ld_rvalid. A following loader read of 0x3010 returns the merged word.
5. if_addr=0x2FFC, then 0x3002, then 0x3000+4*DEPTH → each is granted with mem_en=0, then if_rvalid=1, if_err=1, if_rdata=0. Same check for a loader write → ld_err=1 in the grant cycle.
6. With RD_LAT=2, assert clr low one cycle after a fetch grant → no if_rvalid ever appears. After release, a new fetch completes normally with ld_streak=0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between the fetch stage and the
// loader/debug port. One access per cycle; read data returns tagged to its owner
// after RD_LAT cycles. Fetch is stalled while the loader holds the port, but is
// guaranteed a slot after MAX_LD consecutive loader grants.
module imem_port_arbiter #(
    parameter logic [31:0] BASE   = 32'h0000_3000,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned MAX_LD = 4
) (
    input  logic              clk,
    input  logic              clr,
    // fetch port
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    // loader / debug port
    input  logic              ld_req,
    input  logic [3:0]        ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              ld_err,
    // memory macro
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_LD + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LD);

    logic [SW-1:0]     streak_q, streak_d;
    logic [RD_LAT-1:0] pv_q, pv_d;   // response valid per stage
    logic [RD_LAT-1:0] po_q, po_d;   // owner per stage: 1 = loader
    logic [RD_LAT-1:0] pe_q, pe_d;   // bad-address flag per stage

    logic        ld_take, if_take;
    logic [31:0] sel_addr, sel_off;
    logic        sel_ok;
    logic        push, push_owner;
    logic        out_v, out_o, out_e;

    // Arbitration: loader by default, fetch when idle loader or streak exhausted.
    always_comb begin
        ld_take  = clr && ld_req && !(if_req && (streak_q == STREAK_MAX));
        if_take  = clr && if_req && !ld_take;
        if_gnt   = if_take;
        ld_gnt   = ld_take;
        if_stall = clr && if_req && !if_take;
    end

    // Address decode of the winning requester and combinational memory drive.
    always_comb begin
        sel_addr = ld_take ? ld_addr : if_addr;
        sel_off  = sel_addr - BASE;
        // off < 4*DEPTH is the same as no bits set above the word-address field
        sel_ok   = (sel_off[1:0] == 2'b00) && ((sel_off >> (ADDR_W + 2)) == 32'd0);

        mem_en    = (ld_take || if_take) && sel_ok;
        mem_we    = (ld_take && sel_ok) ? ld_we : 4'b0000;
        mem_addr  = clr ? sel_off[ADDR_W+1:2] : '0;
        mem_wdata = clr ? ld_wdata : 32'h0;

        push       = if_take || (ld_take && (ld_we == 4'b0000));
        push_owner = ld_take;
    end

    // Streak: counts loader wins while fetch waits, saturating at MAX_LD.
    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_take) begin
            streak_d = '0;
        end else if (ld_take && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Response pipeline shift: stage 0 takes the current grant.
    always_comb begin
        pv_d = (pv_q << 1) | RD_LAT'(push);
        po_d = (po_q << 1) | RD_LAT'(push_owner);
        pe_d = (pe_q << 1) | RD_LAT'(!sel_ok);
    end

    // State registers; reset drops every read in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            streak_q <= '0;
            pv_q     <= '0;
            po_q     <= '0;
            pe_q     <= '0;
        end else begin
            streak_q <= streak_d;
            pv_q     <= pv_d;
            po_q     <= po_d;
            pe_q     <= pe_d;
        end
    end

    // Steer the oldest stage to its owner; data is zeroed when absent or bad.
    always_comb begin
        out_v     = pv_q[RD_LAT-1];
        out_o     = po_q[RD_LAT-1];
        out_e     = pe_q[RD_LAT-1];
        if_rvalid = out_v && !out_o;
        ld_rvalid = out_v && out_o;
        if_err    = if_rvalid && out_e;
        if_rdata  = (if_rvalid && !out_e) ? mem_rdata : 32'h0;
        ld_rdata  = (ld_rvalid && !out_e) ? mem_rdata : 32'h0;
        // write errors are flagged in the grant cycle since writes never respond
        ld_err    = (ld_rvalid && out_e) ||
                    (ld_take && (ld_we != 4'b0000) && !sel_ok);
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural model of the arbiter.
module tb_imem_port_arbiter;

    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned MAX_LD = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              clr;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt, if_stall, if_rvalid, if_err;
    logic [31:0]       if_rdata;
    logic              ld_req;
    logic [3:0]        ld_we;
    logic [31:0]       ld_addr, ld_wdata;
    logic              ld_gnt, ld_rvalid, ld_err;
    logic [31:0]       ld_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    imem_port_arbiter #(
        .BASE   (BASE),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .MAX_LD (MAX_LD)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_stall  (if_stall),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .ld_err    (ld_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    // Memory macro with RD_LAT read latency, driven only by the DUT.
    logic [31:0] macro_mem [DEPTH];
    logic [31:0] rd_pipe [RD_LAT];
    bit          macro_init = 1'b0;
    always @(posedge clk) begin
        if (!macro_init) begin
            for (int i = 0; i < int'(DEPTH); i++) macro_mem[i] <= init_word(i);
            macro_init <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) macro_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && mem_we == 4'b0000) ? macro_mem[mem_addr] : 32'hDEAD_BEEF;
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model: expected memory image, loader streak and response queue.
    typedef struct {
        int          due;
        bit          owner;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] ref_mem [DEPTH];
    bit          ref_init = 1'b0;
    int          cyc = 0;
    int          streak_m = 0;
    bit          if_taken = 1'b0, ld_taken = 1'b0;
    bit          rec_on = 1'b0;
    logic [9:0]  pat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rsp_t        r;
        bit          e_if_rv, e_ld_rv, e_if_er, e_ld_er, g_ld, g_if, ok, wr;
        logic [31:0] e_if_rd, e_ld_rd, a, off;
        if (!ref_init) begin
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if_taken = if_req && if_gnt;
        ld_taken = ld_req && ld_gnt;
        if (rec_on) pat = {pat[8:0], if_gnt};
        if (!clr) begin
            rq.delete();
            streak_m = 0;
            check_eq("rst_if_gnt", 32'(if_gnt), 0);
            check_eq("rst_ld_gnt", 32'(ld_gnt), 0);
            check_eq("rst_if_stall", 32'(if_stall), 0);
            check_eq("rst_if_rvalid", 32'(if_rvalid), 0);
            check_eq("rst_ld_rvalid", 32'(ld_rvalid), 0);
            check_eq("rst_if_rdata", if_rdata, 0);
            check_eq("rst_ld_rdata", ld_rdata, 0);
            check_eq("rst_errs", {30'd0, if_err, ld_err}, 0);
            check_eq("rst_mem_en", 32'(mem_en), 0);
            check_eq("rst_mem_we", 32'(mem_we), 0);
        end else begin
            e_if_rv = 0; e_ld_rv = 0; e_if_er = 0; e_ld_er = 0;
            e_if_rd = 0; e_ld_rd = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.owner) begin
                    e_ld_rv = 1; e_ld_er = r.err; e_ld_rd = r.data;
                end else begin
                    e_if_rv = 1; e_if_er = r.err; e_if_rd = r.data;
                end
            end
            check_eq("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
            check_eq("if_rdata", if_rdata, e_if_rd);
            check_eq("if_err", 32'(if_err), 32'(e_if_er));
            check_eq("ld_rvalid", 32'(ld_rvalid), 32'(e_ld_rv));
            check_eq("ld_rdata", ld_rdata, e_ld_rd);

            g_ld = ld_req && !(if_req && streak_m == int'(MAX_LD));
            g_if = if_req && !g_ld;
            check_eq("if_gnt", 32'(if_gnt), 32'(g_if));
            check_eq("ld_gnt", 32'(ld_gnt), 32'(g_ld));
            check_eq("if_stall", 32'(if_stall), 32'(if_req && !g_if));

            a   = g_ld ? ld_addr : if_addr;
            off = a - BASE;
            ok  = (off % 4 == 0) && (longint'(off) < 4 * longint'(DEPTH));
            wr  = g_ld && (ld_we != 4'b0000);
            check_eq("mem_en", 32'(mem_en), 32'((g_ld || g_if) && ok));
            if ((g_ld || g_if) && ok) check_eq("mem_addr", 32'(mem_addr), off / 4);
            check_eq("mem_we", 32'(mem_we), (g_ld && ok) ? 32'(ld_we) : 0);
            if (wr && ok) check_eq("mem_wdata", mem_wdata, ld_wdata);
            check_eq("ld_err", 32'(ld_err), 32'(e_ld_er || (wr && !ok)));

            if (g_if || (g_ld && !wr)) begin
                r.due   = cyc + RD_LAT;
                r.owner = g_ld;
                r.err   = !ok;
                r.data  = ok ? ref_mem[off / 4] : 32'h0;
                rq.push_back(r);
            end
            if (wr && ok)
                for (int b = 0; b < 4; b++)
                    if (ld_we[b]) ref_mem[off / 4][8*b +: 8] = ld_wdata[8*b +: 8];

            if (!if_req || g_if) streak_m = 0;
            else if (g_ld && streak_m < int'(MAX_LD)) streak_m++;
        end
    end

    // Apply one cycle of stimulus starting just after a rising edge.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr,
                         input logic [3:0] lw, input logic [31:0] la, input logic [31:0] lwd);
        if_req = ir; if_addr = ia;
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return BASE - 32'd4;
            1: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            2: return BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 3));
            default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        clr = 1'b0;
        if_req = 0; if_addr = 0; ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // single fetch, then a back-to-back fetch stream
        drive(1, BASE, 0, 0, 0, 0);
        drive(1, BASE + 4, 0, 0, 0, 0);
        drive(1, BASE + 8, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        // contention: both held for 10 cycles
        rec_on = 1'b1;
        repeat (10) drive(1, BASE + 32'h20, 1, 4'b0000, BASE + 32'h24, 0);
        rec_on = 1'b0;
        check_eq("arb_pattern", 32'(pat), 32'b00_0010_0001);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        // partial write then read-back of the merged word
        drive(0, 0, 1, 4'b0011, BASE + 32'h10, 32'hAABB_CCDD);
        drive(0, 0, 1, 4'b0000, BASE + 32'h10, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        // out-of-range and misaligned accesses
        drive(1, BASE - 4, 0, 0, 0, 0);
        drive(1, BASE + 2, 0, 0, 0, 0);
        drive(1, BASE + 4 * DEPTH, 0, 0, 0, 0);
        drive(0, 0, 1, 4'b1111, BASE - 4, 32'h1111_2222);
        drive(0, 0, 1, 4'b0000, BASE + 32'h3, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        // reset while a fetch read is in flight; the response must vanish
        drive(1, BASE, 0, 0, 0, 0);
        if_req = 0;
        clr = 1'b0;
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        clr = 1'b1;
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        drive(1, BASE + 4, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        // randomized traffic honouring the hold-until-granted handshake
        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 200) begin
                clr = 1'b0;
                drive(0, 0, 0, 0, 0, 0);
                clr = 1'b1;
            end
            if (!if_req || if_taken) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!ld_req || ld_taken) begin
                ld_req   = ($urandom_range(0, 1) != 0);
                ld_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
                ld_addr  = rand_addr();
                ld_wdata = $urandom;
            end
            @(posedge clk);
            #1;
        end
        repeat (6) drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
